// File: rtl/cfa_window_ctrl.sv
// Sequencer for the CFA 3x3 line buffer: accepts a raster Bayer stream, drives the buffer
// shift enable/data, and flags interior windows with centre coordinate and Bayer phase.
// Optional build macro CFA_CTRL_ERR_EN adds a sticky err output for truncated/orphan pixels.
module cfa_window_ctrl #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int PIX_W     = 8,
    parameter int BAYER_PAT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sof,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     pix_ready,
    output logic                     buf_en,
    output logic [PIX_W-1:0]         buf_din,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic [1:0]               bayer_phase,
    output logic                     frame_done,
    output logic                     busy
`ifdef CFA_CTRL_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [1:0]       PAT      = 2'(BAYER_PAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [ROW_W-1:0] row_r, row_s;
    logic [COL_W-1:0] col_r, col_s;
    logic             accept_s;
    logic             store_s;
    logic             last_s;
    logic             err_set_s;
    logic [ROW_W-1:0] st_row_s;
    logic [COL_W-1:0] st_col_s;

    // coordinates of the pixel currently presented on buf_din
    logic [ROW_W-1:0] s1_row_r;
    logic [COL_W-1:0] s1_col_r;
    logic             s1_last_r;
    logic             last_win_r;
    logic             win_hit_s;
    logic [ROW_W-1:0] ctr_row_s;
    logic [COL_W-1:0] ctr_col_s;

    assign accept_s = pix_valid & pix_ready;

    // Next-state, position counters and store decision for the pixel on the input port
    always_comb begin
        state_s   = state_r;
        row_s     = row_r;
        col_s     = col_r;
        store_s   = 1'b0;
        last_s    = 1'b0;
        err_set_s = 1'b0;
        st_row_s  = {ROW_W{1'b0}};
        st_col_s  = {COL_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (accept_s && sof) begin
                    store_s = 1'b1;
                    row_s   = {ROW_W{1'b0}};
                    col_s   = COL_W'(1);
                    state_s = ST_ACTIVE;
                end else if (accept_s) begin
                    err_set_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (accept_s && sof) begin
                    // a new frame start truncates the current one; restart at (0,0)
                    store_s   = 1'b1;
                    err_set_s = 1'b1;
                    row_s     = {ROW_W{1'b0}};
                    col_s     = COL_W'(1);
                end else if (accept_s) begin
                    store_s  = 1'b1;
                    st_row_s = row_r;
                    st_col_s = col_r;
                    if (col_r == COL_LAST) begin
                        col_s = {COL_W{1'b0}};
                        if (row_r == ROW_LAST) begin
                            last_s  = 1'b1;
                            row_s   = {ROW_W{1'b0}};
                            state_s = ST_DONE;
                        end else begin
                            row_s = row_r + ROW_W'(1);
                        end
                    end else begin
                        col_s = col_r + COL_W'(1);
                    end
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Window qualification for the pixel just shifted into the buffer
    always_comb begin
        win_hit_s = buf_en && (s1_row_r >= ROW_W'(2)) && (s1_col_r >= COL_W'(2));
        ctr_row_s = s1_row_r - ROW_W'(1);
        ctr_col_s = s1_col_r - COL_W'(1);
    end

    // State and position registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            row_r   <= {ROW_W{1'b0}};
            col_r   <= {COL_W{1'b0}};
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            col_r   <= col_s;
        end
    end

    // Handshake, buffer drive and window reporting pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_ready   <= 1'b0;
            busy        <= 1'b0;
            buf_en      <= 1'b0;
            buf_din     <= {PIX_W{1'b0}};
            s1_row_r    <= {ROW_W{1'b0}};
            s1_col_r    <= {COL_W{1'b0}};
            s1_last_r   <= 1'b0;
            win_valid   <= 1'b0;
            win_row     <= {ROW_W{1'b0}};
            win_col     <= {COL_W{1'b0}};
            bayer_phase <= 2'b00;
            last_win_r  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            pix_ready  <= (state_s != ST_DONE);
            busy       <= (state_s == ST_ACTIVE) || (state_s == ST_DONE);
            buf_en     <= store_s;
            if (store_s) begin
                buf_din <= pix_data;
            end
            s1_row_r   <= st_row_s;
            s1_col_r   <= st_col_s;
            s1_last_r  <= last_s;
            win_valid  <= win_hit_s;
            if (win_hit_s) begin
                win_row     <= ctr_row_s;
                win_col     <= ctr_col_s;
                bayer_phase <= {ctr_row_s[0], ctr_col_s[0]} ^ PAT;
            end
            last_win_r <= buf_en & s1_last_r;
            frame_done <= last_win_r;
        end
    end

`ifdef CFA_CTRL_ERR_EN
    // Sticky protocol error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= err | err_set_s;
        end
    end
`endif

endmodule

// File: tb/tb_cfa_window_ctrl.sv
// Scoreboard bench for cfa_window_ctrl on a 4x4 frame: a linear-index frame model predicts
// buf_din, windows and frame_done with cycle stamps; a monitor checks them against a buffer model.
module tb_cfa_window_ctrl;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int PW  = 8;
    localparam int PAT = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_ready, buf_en, win_valid, frame_done, busy;
    logic [PW-1:0] buf_din;
    logic [1:0]    win_row, win_col, bayer_phase;
`ifdef CFA_CTRL_ERR_EN
    logic          err;
`endif

    cfa_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .BAYER_PAT(PAT)) dut (
        .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .buf_en(buf_en), .buf_din(buf_din), .win_valid(win_valid),
        .win_row(win_row), .win_col(win_col), .bayer_phase(bayer_phase),
        .frame_done(frame_done), .busy(busy)
`ifdef CFA_CTRL_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int stamp; logic [7:0] data; } pix_e_t;
    typedef struct { int stamp; int row; int col; int ph; logic [71:0] win; } win_e_t;
    pix_e_t pix_q[$];
    win_e_t win_q[$];
    int     fd_q[$];

    // frame model: linear pixel index within the current frame
    int         pos = 0;
    bit         in_frame = 1'b0;
    int         final_edge = -10;
    bit         err_exp = 1'b0;
    logic [7:0] img [0:W*H-1];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // external 3x3 line buffer: shift register of two lines plus three pixels
    logic [7:0] lb [0:2*W+2];
    always @(posedge clk) begin
        if (buf_en) begin
            for (int i = 2*W+2; i > 0; i--) lb[i] <= lb[i-1];
            lb[0] <= buf_din;
        end
    end

    function automatic logic [71:0] lb_win();
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[(dr*3+dc)*8 +: 8] = lb[dr*W+dc];
        return w;
    endfunction

    function automatic logic [71:0] outs_now();
        logic [71:0] o;
        o = 72'({pix_ready, buf_en, buf_din, win_valid, win_row, win_col, bayer_phase, frame_done, busy});
`ifdef CFA_CTRL_ERR_EN
        o[71] = err;
`endif
        return o;
    endfunction

    // monitor: pop and compare whenever the DUT presents an output
    pix_e_t pe;
    win_e_t we;
    int     fe;
    always @(negedge clk) begin
        if (rst) begin
            if (buf_en) begin
                if (pix_q.size() == 0) chk("buf_en_unexpected", 72'(1), 72'(0));
                else begin
                    pe = pix_q.pop_front();
                    chk("buf_en_time", 72'(cyc), 72'(pe.stamp));
                    chk("buf_din", 72'(buf_din), 72'(pe.data));
                end
            end
            if (win_valid) begin
                if (win_q.size() == 0) chk("win_valid_unexpected", 72'(1), 72'(0));
                else begin
                    we = win_q.pop_front();
                    chk("win_time", 72'(cyc), 72'(we.stamp));
                    chk("win_centre_phase", 72'({win_row, win_col, bayer_phase}),
                        72'({2'(we.row), 2'(we.col), 2'(we.ph)}));
                    chk("win_pixels", lb_win(), we.win);
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) chk("frame_done_unexpected", 72'(1), 72'(0));
                else begin
                    fe = fd_q.pop_front();
                    chk("frame_done_time", 72'(cyc), 72'(fe));
                end
            end
        end
    end

    // reference: what an accepted pixel at edge a must produce
    task automatic model_accept(input bit s, input logic [7:0] d, input int a);
        int r, c;
        logic [71:0] w;
        pix_e_t np;
        win_e_t nw;
        if (s) begin
            if (in_frame) err_exp = 1'b1;
            pos = 0;
            in_frame = 1'b1;
        end else if (in_frame) begin
            pos++;
        end else begin
            err_exp = 1'b1;
            return;
        end
        img[pos] = d;
        np.stamp = a;
        np.data  = d;
        pix_q.push_back(np);
        r = pos / W;
        c = pos % W;
        if (r >= 2 && c >= 2) begin
            w = '0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    w[(dr*3+dc)*8 +: 8] = img[(r-dr)*W + (c-dc)];
            nw.stamp = a + 1;
            nw.row   = r - 1;
            nw.col   = c - 1;
            nw.ph    = (((r-1) % 2) * 2 + ((c-1) % 2)) ^ PAT;
            nw.win   = w;
            win_q.push_back(nw);
        end
        if (pos == W*H-1) begin
            fd_q.push_back(a + 2);
            in_frame   = 1'b0;
            final_edge = a;
        end
    endtask

    task automatic cycle_checks();
        chk("pix_ready", 72'(pix_ready), 72'((cyc == final_edge) ? 0 : 1));
        chk("busy", 72'(busy), 72'((in_frame || cyc == final_edge) ? 1 : 0));
    endtask

    task automatic send(input bit s, input logic [7:0] d, input int gap_pct);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            cycle_checks();
            if ($urandom_range(99) < gap_pct) begin
                pix_valid = 1'b0;
                sof       = 1'b0;
                pix_data  = 8'($urandom);
            end else begin
                pix_valid = 1'b1;
                sof       = s;
                pix_data  = d;
                if (pix_ready) begin
                    model_accept(s, d, cyc + 1);
                    return;
                end
            end
        end
        chk("send_timeout", 72'(1), 72'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cycle_checks();
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    task automatic send_frame(input int n, input bit seq, input int gap_pct);
        for (int i = 0; i < n; i++) send(i == 0, seq ? 8'(i) : 8'($urandom), gap_pct);
    endtask

    task automatic check_err();
`ifdef CFA_CTRL_ERR_EN
        chk("err", 72'(err), 72'(err_exp));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("reset_outputs", outs_now(), 72'(0));
        pix_q.delete();
        win_q.delete();
        fd_q.delete();
        in_frame   = 1'b0;
        final_edge = -10;
        err_exp    = 1'b0;
        pix_valid  = 1'b0;
        sof        = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hold_outputs", outs_now(), 72'(0));
        #2 rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 72'(pix_ready), 72'(1));
        chk("win_valid_after_reset", 72'(win_valid), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        // back-to-back frame 0..15
        send_frame(W*H, 1'b1, 0);
        idle(5);
        check_err();
        // same frame with valid gaps
        send_frame(W*H, 1'b1, 50);
        idle(5);
        // orphans, then a random frame
        for (int i = 0; i < 5; i++) send(1'b0, 8'($urandom), 0);
        send_frame(W*H, 1'b0, 20);
        idle(5);
        check_err();
        // truncated frame: sof arrives at pixel 9
        send_frame(9, 1'b1, 0);
        send_frame(W*H, 1'b0, 0);
        idle(5);
        check_err();
        // reset during row 2
        send_frame(10, 1'b0, 0);
        do_reset();
        send_frame(W*H, 1'b1, 0);
        idle(5);
        check_err();
        // randomized traffic: gaps, orphans, truncations, back-to-back frames
        for (int i = 0; i < 200; i++)
            send(in_frame ? ($urandom_range(39) == 0) : ($urandom_range(3) != 0), 8'($urandom), 30);
        idle(8);
        check_err();
        chk("pix_queue_drained", 72'(pix_q.size()), 72'(0));
        chk("win_queue_drained", 72'(win_q.size()), 72'(0));
        chk("frame_done_queue_drained", 72'(fd_q.size()), 72'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
